activation_control: RTL

ACTIVATION_CONTROL -- requirements
Module: activation_control

---
 rtl/tpu_pkg.sv | 34 +++
 rtl/pipeline_delay.sv | 27 ++
 rtl/activation_control.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and widths for the activation control path
package tpu_pkg;

  localparam int TPU_ACC_ADDR_WIDTH = 16;
  localparam int TPU_BUF_ADDR_WIDTH = 24;
  localparam int TPU_LENGTH_WIDTH   = 32;

  typedef enum logic [1:0] {
    NO_ACTIVATION = 2'd0,
    RELU          = 2'd1,
    SIGMOID       = 2'd2
  } activation_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  // Per-instruction activation configuration held for the whole run
  typedef struct packed {
    activation_type func;
    logic           is_signed;
  } act_cfg_t;

  // Full activation instruction at the default widths
  typedef struct packed {
    logic [TPU_ACC_ADDR_WIDTH-1:0] acc_addr;
    logic [TPU_BUF_ADDR_WIDTH-1:0] buf_addr;
    logic [TPU_LENGTH_WIDTH-1:0]   length;
    act_cfg_t                      cfg;
  } act_instr_t;

endpackage

// File: rtl/pipeline_delay.sv
// rtl/pipeline_delay.sv - enable-gated shift register of configurable width and depth
module pipeline_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift one stage per enabled cycle; reset empties the whole line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else if (en) begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/activation_control.sv
// rtl/activation_control.sv - sequences accumulator reads and unified buffer writes through the activation unit
module activation_control
  import tpu_pkg::*;
#(
  parameter int ACC_ADDR_WIDTH     = TPU_ACC_ADDR_WIDTH,
  parameter int BUF_ADDR_WIDTH     = TPU_BUF_ADDR_WIDTH,
  parameter int LENGTH_WIDTH       = TPU_LENGTH_WIDTH,
  parameter int ACC_READ_LATENCY   = 2,
  parameter int ACTIVATION_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
  input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr,
  input  logic [LENGTH_WIDTH-1:0]   instr_length,
  input  activation_type            instr_function,
  input  logic                      instr_signed,
  output logic                      acc_read_en,
  output logic [ACC_ADDR_WIDTH-1:0] acc_read_addr,
  output activation_type            act_function,
  output logic                      act_signed,
  output logic                      buf_write_en,
  output logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
  output logic                      busy,
  output logic                      done
);

  localparam int WRITE_LATENCY = ACC_READ_LATENCY + ACTIVATION_LATENCY;

  ctrl_state_t               state, state_next;
  logic [ACC_ADDR_WIDTH-1:0] acc_ptr;
  logic [BUF_ADDR_WIDTH-1:0] buf_ptr;
  logic [LENGTH_WIDTH-1:0]   issue_left;
  logic [LENGTH_WIDTH-1:0]   write_left;
  act_cfg_t                  cfg;
  logic                      zero_pending;
  logic                      act_window;
  logic                      accept;
  logic                      issuing;
  logic [BUF_ADDR_WIDTH:0]   wr_tap;
  logic                      fn_tap;
  logic                      act_on;

  assign issuing        = (state == ISSUE);
  assign instr_ready    = enable && (state == IDLE);
  assign accept         = instr_ready && instr_valid;
  assign busy           = (state != IDLE);
  assign acc_read_addr  = issuing ? acc_ptr : '0;
  assign buf_write_en   = enable && wr_tap[BUF_ADDR_WIDTH];
  assign buf_write_addr = wr_tap[BUF_ADDR_WIDTH-1:0];
  assign act_on         = act_window || fn_tap;
  assign act_function   = act_on ? cfg.func : NO_ACTIVATION;
  assign act_signed     = act_on && cfg.is_signed;

  // Write strobe and its address travel together, arriving one full read+activation latency later
  pipeline_delay #(.WIDTH(BUF_ADDR_WIDTH + 1), .DEPTH(WRITE_LATENCY)) u_write_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .din  ({issuing, (issuing ? buf_ptr : '0)}),
    .dout (wr_tap)
  );

  // Marks rows reaching the activation unit input, used to open the function window
  pipeline_delay #(.WIDTH(1), .DEPTH(ACC_READ_LATENCY)) u_fn_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .din  (issuing),
    .dout (fn_tap)
  );

  // Next-state decode plus read strobe and completion pulse
  always_comb begin
    state_next  = state;
    acc_read_en = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        done = enable && zero_pending;
        if (accept && (instr_length != '0)) state_next = ISSUE;
      end
      ISSUE: begin
        acc_read_en = enable;
        if (enable && (issue_left == LENGTH_WIDTH'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (enable && (write_left == '0)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; enable low holds the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Instruction latch and per-row read/write address counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_ptr      <= '0;
      buf_ptr      <= '0;
      issue_left   <= '0;
      cfg          <= '{func: NO_ACTIVATION, is_signed: 1'b0};
      zero_pending <= 1'b0;
    end else if (accept) begin
      acc_ptr      <= instr_acc_addr;
      buf_ptr      <= instr_buf_addr;
      issue_left   <= instr_length;
      cfg          <= '{func: instr_function, is_signed: instr_signed};
      zero_pending <= (instr_length == '0);
    end else if (enable) begin
      zero_pending <= 1'b0;
      if (issuing) begin
        acc_ptr    <= acc_ptr + ACC_ADDR_WIDTH'(1);
        buf_ptr    <= buf_ptr + BUF_ADDR_WIDTH'(1);
        issue_left <= issue_left - LENGTH_WIDTH'(1);
      end
    end
  end

  // Outstanding writes; reaching zero in DRAIN ends the instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               write_left <= '0;
    else if (accept)       write_left <= instr_length;
    else if (buf_write_en) write_left <= write_left - LENGTH_WIDTH'(1);
  end

  // Function window: opens when the first row reaches the unit, closes with the last write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_window <= 1'b0;
    end else if (enable) begin
      if (buf_write_en && (write_left == LENGTH_WIDTH'(1))) act_window <= 1'b0;
      else if (fn_tap)                                      act_window <= 1'b1;
    end
  end

endmodule
